hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Multi-cycle 32-bit signed/unsigned divider controller that produces the 64-bit HI/LO write-back for DIV/DIVU.
- Sits beside the execute stage.
- Sequences a radix-2 restoring division over 32 cycles and raises a stall request while busy.
- Delivers {remainder, quotient} with a ready strobe so the execute stage can write HI (remainder) and LO (quotient) through the HI/LO register write port.

Parameters:
- DW, 32, operand width; quotient/remainder width. Iteration count equals DW.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- start_i  input  1  execute stage requests a division; held high until ready_o seen
- annul_i  input  1  cancel in-flight division (pipeline flush)
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  DW  dividend
- opdata2_i  input  DW  divisor
- busy_o  input-side stall  output  1  high while the result is pending; pipeline stalls
- ready_o  output  1  result valid this cycle
- result_o  output  2*DW  {remainder[DW-1:0], quotient[DW-1:0]}; upper half goes to HI, lower half to LO

Behaviour:
- States: IDLE, DIVZERO, BUSY, DONE.
- Reset (rst=1 at posedge, any state):
  - state=IDLE, cnt=0, ready_o=0, busy_o=0, result_o=0.
  - Internal dividend register cleared.
  - Wins over every other input.
- IDLE, start_i=1, annul_i=0:
  - If opdata2_i==0, go to DIVZERO.
  - Otherwise latch operands and go to BUSY.
  - If signed_i=1 and an operand is negative, latch its two's-complement magnitude.
  - Record neg_q = signed_i & (op1[DW-1]^op2[DW-1]) and neg_r = signed_i & op1[DW-1].
  - Working register (2*DW+1 bits) = {DW+1 zeros, |op1|}; cnt=0.
- IDLE with start_i=0 or annul_i=1: stay in IDLE.
- DIVZERO: one cycle; result forced to 0; go to DONE.
- BUSY, each cycle:
  - Shift the working register left by 1, then trial-subtract |op2| from its upper DW+1 bits.
  - If the difference is non-negative: keep the difference, set bit 0 = 1.
  - Otherwise: no restore write, bit 0 = 0.
  - cnt increments each cycle. After the iteration with cnt==DW-1, go to DONE.
  - Quotient = working register low DW bits; remainder = upper bits [2*DW:DW+1] after the final shift alignment.
  - Any equivalent formulation is allowed if results match.
- DONE:
  - ready_o=1 and result_o valid.
  - Quotient is negated if neg_q; remainder is negated if neg_r (remainder sign follows the dividend).
  - Stay in DONE while start_i=1. When start_i=0, go to IDLE with ready_o=0 and result_o held.
- busy_o = start_i & ~ready_o, combinational.
  - It is high in the IDLE cycle that accepts a request, in DIVZERO and in BUSY.
  - It is low in DONE.
- Latency: request sampled at edge t.
  - Nonzero divisor: ready_o high in cycle t+DW+1 (t+33 for DW=32).
  - Zero divisor: ready_o high in cycle t+2.
- annul_i=1 in DIVZERO or BUSY: go to IDLE next edge. No ready_o pulse, result_o unchanged.
- annul_i in DONE: go to IDLE.
- Operand changes while BUSY are ignored, because operands are latched.
- start_i dropped mid-BUSY without annul_i: the division completes; DONE then returns to IDLE on the next edge.
- Special cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - Unsigned operands use full DW-bit magnitude.

Test Plan:
- DIVU 100/7, start at t: ready_o=1 at t+33, result_o={32'd2,32'd14}, busy_o high t..t+32.
- DIV -7/2 (0xFFFFFFF9/0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2: quotient 0xFFFFFFFD, remainder 0x1.
- DIVU 0xFFFFFFFF/1: quotient 0xFFFFFFFF, remainder 0. DIV 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Divisor 0: ready_o at t+2, result_o=0; start_i held then dropped gives DONE→IDLE, ready_o low next cycle.
- annul_i at cycle t+10 of a division: IDLE next edge, no ready_o. A new request 25/5 then completes in 33 cycles with {0,5}.
- rst asserted mid-BUSY: all outputs 0 next edge. Back-to-back divisions after reset give correct results.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_ctrl
//  Description : Multi-cycle radix-2 restoring divider controller for DIV and
//                DIVU. Produces {remainder, quotient} for the HI/LO write-back
//                port and stalls the pipeline while a division is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_ctrl #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic [2*DW-1:0]   result_o
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0]    c_IDLE    = 2'd0;
    localparam logic [1:0]    c_DIVZERO = 2'd1;
    localparam logic [1:0]    c_BUSY    = 2'd2;
    localparam logic [1:0]    c_DONE    = 2'd3;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(DW - 1);

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [2*DW:0]   r_dividend;   // {partial remainder (DW+1), dividend/quotient (DW)}
    logic [DW-1:0]   r_divisor;    // divisor magnitude
    logic            r_neg_q;
    logic            r_neg_r;

    logic [DW-1:0]   w_abs1;
    logic [DW-1:0]   w_abs2;
    logic [2*DW:0]   w_shift;
    logic [DW+1:0]   w_diff;
    logic            w_ge;
    logic [2*DW:0]   w_next;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_rem;
    logic [2*DW-1:0] w_result;
    logic            w_unused;

    // Operand magnitudes: signed negatives are converted to two's-complement magnitude
    assign w_abs1 = (signed_i && opdata1_i[DW-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_abs2 = (signed_i && opdata2_i[DW-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step: shift left, trial-subtract the divisor from the upper part.
    // The partial remainder stays below the divisor, so the working register's top
    // bit is always zero before the shift and can be dropped.
    assign w_shift = {r_dividend[2*DW-1:0], 1'b0};
    assign w_diff  = {1'b0, w_shift[2*DW:DW]} - {2'b00, r_divisor};
    assign w_ge    = ~w_diff[DW+1];
    assign w_next  = w_ge ? {w_diff[DW:0], w_shift[DW-1:1], 1'b1} : w_shift;

    // Final sign correction; remainder takes the dividend's sign
    assign w_quot   = w_next[DW-1:0];
    assign w_rem    = w_next[2*DW-1:DW];
    assign w_result = {(r_neg_r ? (~w_rem + 1'b1) : w_rem),
                       (r_neg_q ? (~w_quot + 1'b1) : w_quot)};

    // Bits that are provably zero by construction
    assign w_unused = ^{r_dividend[2*DW]};

    // Stall while a request is outstanding and no result has been delivered
    assign busy_o = start_i & ~ready_o;

    // Division sequencer with registered ready/result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= c_DIVZERO;
                        end else begin
                            r_state    <= c_BUSY;
                            r_dividend <= {{(DW+1){1'b0}}, w_abs1};
                            r_divisor  <= w_abs2;
                            r_neg_q    <= signed_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                            r_neg_r    <= signed_i & opdata1_i[DW-1];
                            r_cnt      <= '0;
                        end
                    end
                end
                c_DIVZERO: begin
                    if (annul_i) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_state  <= c_DONE;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                    end
                end
                c_BUSY: begin
                    if (annul_i) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_dividend <= w_next;
                        r_cnt      <= r_cnt + 1'b1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state  <= c_DONE;
                            ready_o  <= 1'b1;
                            result_o <= w_result;
                        end
                    end
                end
                c_DONE: begin
                    if (annul_i || !start_i) begin
                        r_state <= c_IDLE;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_div_ctrl
//  Description : Self-checking bench for hilo_div_ctrl with a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int          n_pass;
    int          n_total;
    logic [63:0] exp_q[$];
    logic [63:0] last_res;

    hilo_div_ctrl #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .annul_i   (annul),
        .signed_i  (sgn),
        .opdata1_i (op1),
        .opdata2_i (op2),
        .busy_o    (busy),
        .ready_o   (ready),
        .result_o  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: native integer division (truncating, remainder follows dividend)
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint la, lb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            la = longint'(signed'(a));
            lb = longint'(signed'(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    // One complete request; operands are scrambled after acceptance to prove latching
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp, input int exp_lat,
                           input int drop_at, input int hold);
        int          lat;
        int          busy_bad;
        logic [63:0] want;
        @(negedge clk);
        start = 1'b1; op1 = a; op2 = b; sgn = s;
        exp_q.push_back(exp);
        #1 chk({tag, "_busy_accept"}, {63'd0, busy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        op1 = $urandom; op2 = $urandom; sgn = ~s;
        lat = 0; busy_bad = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ready) break;
            if (start && !busy) busy_bad++;
            if (lat == drop_at) start = 1'b0;
        end
        chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        chk({tag, "_result"}, result, want);
        chk({tag, "_busy_hold"}, 64'(busy_bad), 64'd0);
        chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_ready_held"}, {63'd0, ready}, 64'd1);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ready_drop"}, {63'd0, ready}, 64'd0);
        chk({tag, "_result_held"}, result, want);
        last_res = want;
    endtask

    initial begin
        int          stray;
        logic [31:0] ra, rb;
        logic        rs;
        n_pass = 0; n_total = 0;
        rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",  {63'd0, ready}, 64'd0);
        chk("reset_busy",   {63'd0, busy},  64'd0);
        chk("reset_result", result,         64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7",   32'd100,       32'd7,         1'b0, {32'd2, 32'd14},               32, 0, 0);
        run_div("div_m7_2",     32'hFFFFFFF9,  32'h2,         1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},  32, 0, 0);
        run_div("div_7_m2",     32'd7,         32'hFFFFFFFE,  1'b1, {32'h1, 32'hFFFFFFFD},         32, 0, 0);
        run_div("divu_max_1",   32'hFFFFFFFF,  32'h1,         1'b0, {32'h0, 32'hFFFFFFFF},         32, 0, 0);
        run_div("div_ovf",      32'h80000000,  32'hFFFFFFFF,  1'b1, {32'h0, 32'h80000000},         32, 0, 0);
        run_div("div_zero",     32'd1234,      32'd0,         1'b1, 64'd0,                          1, 0, 2);
        run_div("divu_big",     32'hFFFFFFF9,  32'h2,         1'b0, {32'h1, 32'h7FFFFFFC},         32, 0, 0);
        run_div("start_drop",   32'd1000,      32'd33,        1'b0, {32'd10, 32'd30},              32, 5, 0);

        // Annul mid-division: no ready pulse, result untouched
        @(negedge clk);
        start = 1'b1; op1 = 32'd1000; op2 = 32'd3; sgn = 1'b0;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_ready",  {63'd0, ready}, 64'd0);
        chk("annul_result", result, last_res);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) stray++;
        end
        chk("annul_no_ready", 64'(stray), 64'd0);
        run_div("after_annul",  32'd25,        32'd5,         1'b0, {32'd0, 32'd5},                32, 0, 0);

        // Reset in the middle of a division
        @(negedge clk);
        start = 1'b1; op1 = 32'd77; op2 = 32'd5; sgn = 1'b0;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready",  {63'd0, ready}, 64'd0);
        chk("rst_busy",   {63'd0, busy},  64'd0);
        chk("rst_result", result,         64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back divisions after reset, checked against the reference model
        run_div("b2b_a", 32'd9,        32'd4,        1'b0, model(32'd9, 32'd4, 1'b0),              32, 0, 0);
        run_div("b2b_b", 32'hFFFFFF9C, 32'd7,        1'b1, model(32'hFFFFFF9C, 32'd7, 1'b1),       32, 0, 0);
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k < 3) ? ($urandom | 32'd1) : 32'($urandom_range(1, 1000));
            rs = k[0];
            run_div("rand", ra, rb, rs, model(ra, rb, rs), 32, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
